// File: rtl/clap_sequence_decoder_pkg.sv
// Shared types for the clap sequence decoder: FSM state encoding, command
// codes and the saturating clap counter increment.
package clap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKOUT = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DECIDE  = 2'd3
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LIGHT = 2'd1;
    localparam logic [1:0] CMD_FAN   = 2'd2;

    localparam logic [2:0] COUNT_MAX = 3'd7;

    function automatic logic [2:0] sat_inc(input logic [2:0] count);
        logic [2:0] result;
        if (count == COUNT_MAX) begin
            result = COUNT_MAX;
        end else begin
            result = count + 3'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/clap_sequence_decoder_if.sv
// Clap input and command/appliance-state outputs of the clap sequence decoder.
interface clap_sequence_decoder_if;

    logic       clap_in;
    logic       light_on;
    logic       fan_on;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       cmd_reject;
    logic       busy;
    logic [2:0] clap_count;

    modport master (
        output clap_in,
        input  light_on,
        input  fan_on,
        input  cmd_valid,
        input  cmd_code,
        input  cmd_reject,
        input  busy,
        input  clap_count
    );

    modport slave (
        input  clap_in,
        output light_on,
        output fan_on,
        output cmd_valid,
        output cmd_code,
        output cmd_reject,
        output busy,
        output clap_count
    );

endinterface

// File: rtl/clap_sequence_decoder_gap_timer.sv
// Inter-clap gap timer: a free-running counter restarted on each accepted clap,
// with compares for the end of the echo lockout and the sequence timeout.
module clap_gap_timer #(
    parameter int MIN_GAP = 2_500_000,
    parameter int MAX_GAP = 25_000_000,
    parameter int TW      = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic lock_done,
    output logic gap_done
);

    logic [TW-1:0] timer_r;

    // Gap counter: clear has priority over count enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_r <= '0;
        end else if (clr) begin
            timer_r <= '0;
        end else if (en) begin
            timer_r <= timer_r + TW'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    assign lock_done = (timer_r == TW'(MIN_GAP - 1));
    assign gap_done  = (timer_r == TW'(MAX_GAP - 1));

endmodule

// File: rtl/clap_sequence_decoder.sv
// Counts debounced clap rises into sequences and turns a closed sequence of
// two or three claps into a light or fan toggle command.
module clap_sequence_decoder
    import clap_pkg::*;
#(
    parameter int MIN_GAP = 2_500_000,
    parameter int MAX_GAP = 25_000_000,
    parameter int TW      = 25
) (
    input  logic                   clk,
    input  logic                   reset,
    clap_sequence_decoder_if.slave bus
);

    logic       clap_q_r;
    logic       rise_s;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] count_r;
    logic [2:0] count_nxt_s;

    logic       timer_clr_s;
    logic       timer_en_s;
    logic       lock_done_s;
    logic       gap_done_s;

    logic       valid_r;
    logic       valid_nxt_s;
    logic       reject_r;
    logic       reject_nxt_s;
    logic [1:0] code_r;
    logic [1:0] code_nxt_s;
    logic       light_r;
    logic       light_nxt_s;
    logic       fan_r;
    logic       fan_nxt_s;
    logic       busy_r;

    // Resets high so an input already asserted at reset release is not a clap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clap_q_r <= 1'b1;
        end else begin
            clap_q_r <= bus.clap_in;
        end
    end

    assign rise_s = bus.clap_in & ~clap_q_r;

    clap_gap_timer #(
        .MIN_GAP (MIN_GAP),
        .MAX_GAP (MAX_GAP),
        .TW      (TW)
    ) u_gap_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (timer_clr_s),
        .en        (timer_en_s),
        .lock_done (lock_done_s),
        .gap_done  (gap_done_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, timer control and next values of all registered outputs
    always_comb begin
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        timer_clr_s  = 1'b0;
        timer_en_s   = 1'b0;
        valid_nxt_s  = 1'b0;
        reject_nxt_s = 1'b0;
        code_nxt_s   = CMD_NONE;
        light_nxt_s  = light_r;
        fan_nxt_s    = fan_r;

        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    count_nxt_s = 3'd1;
                    timer_clr_s = 1'b1;
                    state_nxt_s = ST_LOCKOUT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                timer_en_s = 1'b1;
                if (lock_done_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_LOCKOUT;
                end
            end
            ST_WAIT: begin
                // A clap on the timeout cycle extends the sequence
                if (rise_s) begin
                    count_nxt_s = sat_inc(count_r);
                    timer_clr_s = 1'b1;
                    state_nxt_s = ST_LOCKOUT;
                end else if (gap_done_s) begin
                    state_nxt_s = ST_DECIDE;
                    case (count_r)
                        3'd2: begin
                            valid_nxt_s = 1'b1;
                            code_nxt_s  = CMD_LIGHT;
                            light_nxt_s = ~light_r;
                        end
                        3'd3: begin
                            valid_nxt_s = 1'b1;
                            code_nxt_s  = CMD_FAN;
                            fan_nxt_s   = ~fan_r;
                        end
                        default: begin
                            reject_nxt_s = 1'b1;
                        end
                    endcase
                end else begin
                    timer_en_s  = 1'b1;
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DECIDE: begin
                count_nxt_s = 3'd0;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                count_nxt_s = 3'd0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output and counter registers, all updated from the FSM's next values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= 3'd0;
            valid_r  <= 1'b0;
            reject_r <= 1'b0;
            code_r   <= CMD_NONE;
            light_r  <= 1'b0;
            fan_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            valid_r  <= valid_nxt_s;
            reject_r <= reject_nxt_s;
            code_r   <= code_nxt_s;
            light_r  <= light_nxt_s;
            fan_r    <= fan_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.light_on   = light_r;
    assign bus.fan_on     = fan_r;
    assign bus.cmd_valid  = valid_r;
    assign bus.cmd_code   = code_r;
    assign bus.cmd_reject = reject_r;
    assign bus.busy       = busy_r;
    assign bus.clap_count = count_r;

endmodule

// File: tb/tb_clap_sequence_decoder.sv
// Directed bench for clap_sequence_decoder with MIN_GAP=4, MAX_GAP=20.
module tb_clap_sequence_decoder;

    localparam int MIN_GAP = 4;
    localparam int MAX_GAP = 20;
    localparam int TW      = 5;
    localparam int SCEN_CYCLES = 60;

    typedef struct {
        int         r0, r1, r2, r3, r4;
        int         dec;
        logic       is_valid;
        logic [1:0] code;
        logic       light;
        logic       fan;
        logic [2:0] cnt;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    int         pulses;
    int         dec_edge;
    logic       seen_valid;
    logic       seen_reject;
    logic [1:0] seen_code;
    logic [2:0] max_cnt;
    logic       max_busy;
    logic       both_high;

    vec_t vecs[7];

    clap_sequence_decoder_if bus ();

    clap_sequence_decoder #(
        .MIN_GAP (MIN_GAP),
        .MAX_GAP (MAX_GAP),
        .TW      (TW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int r0, input int r1, input int r2, input int r3,
                                input int r4, input int dec, input logic is_valid,
                                input logic [1:0] code, input logic light, input logic fan,
                                input logic [2:0] cnt);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3; v.r4 = r4;
        v.dec = dec; v.is_valid = is_valid; v.code = code;
        v.light = light; v.fan = fan; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs ncyc edges; a rise listed at c makes clap_in high just before edge c
    task automatic run(input vec_t v, input int ncyc, input logic hold);
        pulses = 0; dec_edge = -1; seen_valid = 1'b0; seen_reject = 1'b0;
        seen_code = 2'd0; max_cnt = 3'd0; max_busy = 1'b0; both_high = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            bus.clap_in = hold | (c == v.r0) | (c == v.r1) | (c == v.r2) |
                          (c == v.r3) | (c == v.r4);
            @(posedge clk);
            #1;
            if (bus.cmd_valid || bus.cmd_reject) begin
                pulses++;
                dec_edge    = c;
                seen_valid  = bus.cmd_valid;
                seen_reject = bus.cmd_reject;
                seen_code   = bus.cmd_code;
            end
            if (bus.cmd_valid && bus.cmd_reject) both_high = 1'b1;
            if (bus.clap_count > max_cnt) max_cnt = bus.clap_count;
            if (bus.busy) max_busy = 1'b1;
        end
        bus.clap_in = 1'b0;
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_edge"}, dec_edge, v.dec);
        chk({tag, "_valid"}, int'(seen_valid), int'(v.is_valid));
        chk({tag, "_reject"}, int'(seen_reject), int'(!v.is_valid));
        chk({tag, "_code"}, int'(seen_code), int'(v.code));
        chk({tag, "_light"}, int'(bus.light_on), int'(v.light));
        chk({tag, "_fan"}, int'(bus.fan_on), int'(v.fan));
        chk({tag, "_count"}, int'(max_cnt), int'(v.cnt));
        chk({tag, "_exclusive"}, int'(both_high), 0);
        chk({tag, "_busy_end"}, int'(bus.busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_light"}, int'(bus.light_on), 0);
        chk({tag, "_fan"}, int'(bus.fan_on), 0);
        chk({tag, "_valid"}, int'(bus.cmd_valid), 0);
        chk({tag, "_code"}, int'(bus.cmd_code), 0);
        chk({tag, "_reject"}, int'(bus.cmd_reject), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_count"}, int'(bus.clap_count), 0);
    endtask

    initial begin
        vec_t none;
        n_cmp = 0;
        n_fail = 0;
        none = mk(0, 0, 0, 0, 0, 0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0);

        // Appliance states accumulate from one row to the next
        vecs[0] = mk(10, 20, 0, 0, 0, 40, 1'b1, 2'd1, 1'b1, 1'b0, 3'd2); // double
        vecs[1] = mk(10, 20, 0, 0, 0, 40, 1'b1, 2'd1, 1'b0, 1'b0, 3'd2); // double again
        vecs[2] = mk(10, 18, 30, 0, 0, 50, 1'b1, 2'd2, 1'b0, 1'b1, 3'd3); // triple
        vecs[3] = mk(10, 13, 0, 0, 0, 30, 1'b0, 2'd0, 1'b0, 1'b1, 3'd1); // echo ignored
        vecs[4] = mk(10, 15, 0, 0, 0, 35, 1'b1, 2'd1, 1'b1, 1'b1, 3'd2); // first allowed
        vecs[5] = mk(10, 16, 22, 28, 34, 54, 1'b0, 2'd0, 1'b1, 1'b1, 3'd5); // five claps
        vecs[6] = mk(10, 30, 0, 0, 0, 50, 1'b1, 2'd1, 1'b0, 1'b1, 3'd2); // timeout tie

        bus.clap_in = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run(vecs[i], SCEN_CYCLES, 1'b0);
            check_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in WAIT after two claps: outputs drop without a clock edge
        run(mk(10, 20, 0, 0, 0, 0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0), 26, 1'b0);
        chk("midseq_busy", int'(bus.busy), 1);
        chk("midseq_count", int'(bus.clap_count), 2);
        chk("midseq_fan_before", int'(bus.fan_on), 1);
        chk("midseq_no_pulse", pulses, 0);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run(none, 40, 1'b0);
        chk("post_reset_pulses", pulses, 0);
        chk("post_reset_busy", int'(max_busy), 0);

        // clap_in held high through reset release is not a clap
        bus.clap_in = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run(none, 30, 1'b1);
        chk("held_busy", int'(max_busy), 0);
        chk("held_count", int'(max_cnt), 0);
        chk("held_pulses", pulses, 0);

        run(vecs[0], SCEN_CYCLES, 1'b0);
        check_vec(vecs[0], "after_held");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
